// File: rtl/code_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_fsm
// Purpose  : Multi-digit code lock. Mealy accept/reject pulses, a lockout
//            after MAX_FAIL consecutive wrong entries, and timed auto-relock.
//            Optional macro LOCK_REPROG_EN lets digits entered while OPEN
//            overwrite the stored secret.
// Revision : 1.0 - initial release
// ============================================================================
module code_lock_fsm #(
  parameter int DIGIT_W                    = 4,
  parameter int CODE_LEN                   = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] SECRET = 16'h2580,
  parameter int MAX_FAIL                   = 3,
  parameter int OPEN_CYCLES                = 8,
  parameter int LOCKOUT_CYCLES             = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            digit_valid,
  input  logic [DIGIT_W-1:0]              digit,
  input  logic                            abort,
  input  logic                            relock,
  output logic                            open_pulse,
  output logic                            alarm,
  output logic                            unlocked,
  output logic                            locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int SW   = CODE_LEN * DIGIT_W;
  localparam int IW   = $clog2(CODE_LEN);
  localparam int FCW  = $clog2(MAX_FAIL + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [IW-1:0] LAST = IW'(CODE_LEN - 1);

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t         state;
  logic [IW-1:0]  idx;
  logic           mism;
  logic [TW-1:0]  timer;
  logic [SW-1:0]  secret;
  logic [DIGIT_W-1:0] sec_digit;
  logic           final_digit;
  logic           code_ok;
  logic [FCW-1:0] fail_inc;

`ifdef LOCK_REPROG_EN
  logic [SW-1:0]  stage;
  logic [SW-1:0]  staged_secret;

  // Reprogram staging: current partial secret with this digit placed at idx
  always_comb begin
    staged_secret = stage;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx == IW'(i)) begin
        staged_secret[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
      end
    end
  end
`else
  assign secret = SECRET;
`endif

  // Select the secret digit at the current entry position (first digit = MSD)
  always_comb begin
    sec_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (idx == IW'(i)) begin
        sec_digit = secret[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Abort wins over a simultaneous digit, so a dropped digit never completes a code
  assign final_digit = (state == ENTRY) && digit_valid && !abort && (idx == LAST);
  assign code_ok     = !mism && (digit == sec_digit);
  assign open_pulse  = final_digit && code_ok;
  assign alarm       = final_digit && !code_ok;
  assign fail_inc    = fail_cnt + FCW'(1);

  // Main state machine with registered Moore outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ENTRY;
      idx        <= '0;
      mism       <= 1'b0;
      timer      <= '0;
      fail_cnt   <= '0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
`ifdef LOCK_REPROG_EN
      secret     <= SECRET;
      stage      <= '0;
`endif
    end else begin
      case (state)
        ENTRY: begin
          if (abort) begin
            idx  <= '0;
            mism <= 1'b0;
          end else if (digit_valid) begin
            if (idx == LAST) begin
              idx  <= '0;
              mism <= 1'b0;
              if (code_ok) begin
                state    <= OPEN;
                timer    <= TW'(OPEN_CYCLES);
                fail_cnt <= '0;
                unlocked <= 1'b1;
              end else begin
                fail_cnt <= fail_inc;
                if (fail_inc == FCW'(MAX_FAIL)) begin
                  state      <= LOCKOUT;
                  timer      <= TW'(LOCKOUT_CYCLES);
                  locked_out <= 1'b1;
                end
              end
            end else begin
              // Wrong digits are only recorded, never acted on early
              idx  <= idx + IW'(1);
              mism <= mism | (digit != sec_digit);
            end
          end
        end

        OPEN: begin
          timer <= timer - TW'(1);
`ifdef LOCK_REPROG_EN
          if (relock || abort ||
              (timer == TW'(1) && !(digit_valid && idx == LAST))) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
            idx      <= '0;
            mism     <= 1'b0;
            timer    <= '0;
          end else if (digit_valid) begin
            if (idx == LAST) begin
              secret   <= staged_secret;
              state    <= ENTRY;
              unlocked <= 1'b0;
              idx      <= '0;
              mism     <= 1'b0;
              timer    <= '0;
            end else begin
              stage <= staged_secret;
              idx   <= idx + IW'(1);
            end
          end
`else
          if (relock || timer == TW'(1)) begin
            state    <= ENTRY;
            unlocked <= 1'b0;
            idx      <= '0;
            mism     <= 1'b0;
            timer    <= '0;
          end
`endif
        end

        LOCKOUT: begin
          timer <= timer - TW'(1);
          if (timer == TW'(1)) begin
            state      <= ENTRY;
            locked_out <= 1'b0;
            fail_cnt   <= '0;
            timer      <= '0;
          end
        end

        default: begin
          state      <= ENTRY;
          idx        <= '0;
          mism       <= 1'b0;
          timer      <= '0;
          fail_cnt   <= '0;
          unlocked   <= 1'b0;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_code_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_fsm
// Purpose  : Directed self-checking bench for code_lock_fsm (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_lock_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       abort = 1'b0;
  logic       relock = 1'b0;
  logic       open_pulse;
  logic       alarm;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  code_lock_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .digit_valid (digit_valid),
    .digit       (digit),
    .abort       (abort),
    .relock      (relock),
    .open_pulse  (open_pulse),
    .alarm       (alarm),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later
  task automatic drive(input logic v, input logic [3:0] d, input logic ab, input logic rl);
    @(negedge clk);
    digit_valid = v;
    digit       = d;
    abort       = ab;
    relock      = rl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic enter_code(input logic [15:0] code, input logic exp_open,
                            input logic exp_alarm, input string tag);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, code[15-4*i -: 4], 1'b0, 1'b0);
      check({tag, "_open"},  open_pulse, (i == 3) ? exp_open  : 1'b0);
      check({tag, "_alarm"}, alarm,      (i == 3) ? exp_alarm : 1'b0);
    end
  endtask

  logic [15:0] good = 16'h2580;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_unlocked",   unlocked,   0);
    check("rst_locked_out", locked_out, 0);
    check("rst_fail_cnt",   fail_cnt,   0);
    check("rst_open",       open_pulse, 0);
    check("rst_alarm",      alarm,      0);

    // Correct code, then exactly 8 open cycles
    enter_code(good, 1'b1, 1'b0, "c1");
    for (int i = 0; i < 8; i++) begin
      idle();
      check("c1_unlocked", unlocked, 1);
      check("c1_alarm_open", alarm, 0);
    end
    idle();
    check("c1_relocked", unlocked, 0);

    // Two wrong entries then a correct one
    enter_code(16'h2581, 1'b0, 1'b1, "w1");
    idle();
    check("w1_fail_cnt", fail_cnt, 1);
    enter_code(16'h1580, 1'b0, 1'b1, "w2");
    idle();
    check("w2_fail_cnt", fail_cnt, 2);
    check("w2_not_locked", locked_out, 0);
    enter_code(good, 1'b1, 1'b0, "c2");
    idle();
    check("c2_fail_cnt", fail_cnt, 0);
    check("c2_unlocked_cyc1", unlocked, 1);

    // Early relock on the third open cycle
    idle();
    drive(1'b0, 4'd0, 1'b0, 1'b1);
    check("rl_unlocked_cyc3", unlocked, 1);
    idle();
    check("rl_unlocked_after", unlocked, 0);

    // Three wrong entries trigger a 16-cycle lockout
    enter_code(16'h1111, 1'b0, 1'b1, "l1");
    enter_code(16'h1111, 1'b0, 1'b1, "l2");
    enter_code(16'h1111, 1'b0, 1'b1, "l3");
    for (int i = 0; i < 16; i++) begin
      if (i < 4) drive(1'b1, good[15-4*i -: 4], 1'b0, 1'b0);
      else       idle();
      check("lo_locked_out", locked_out, 1);
      check("lo_open",  open_pulse, 0);
      check("lo_alarm", alarm, 0);
      if (i == 0) check("lo_fail_cnt", fail_cnt, 3);
    end
    idle();
    check("lo_released", locked_out, 0);
    check("lo_fail_clr", fail_cnt, 0);
    enter_code(good, 1'b1, 1'b0, "lo_after");
    repeat (9) idle();
    check("lo_after_closed", unlocked, 0);

    // Abort with a simultaneous digit drops the digit and the partial entry
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    drive(1'b1, 4'd8, 1'b1, 1'b0);
    check("ab_open",  open_pulse, 0);
    check("ab_alarm", alarm, 0);
    enter_code(good, 1'b1, 1'b0, "ab_after");
    idle();
    check("ab_fail_cnt", fail_cnt, 0);
    repeat (8) idle();

    // Mid-entry reset clears the partial entry
    drive(1'b1, 4'd2, 1'b0, 1'b0);
    drive(1'b1, 4'd5, 1'b0, 1'b0);
    drive(1'b1, 4'd8, 1'b0, 1'b0);
    @(negedge clk);
    digit_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("mr_open",       open_pulse, 0);
    check("mr_alarm",      alarm, 0);
    check("mr_unlocked",   unlocked, 0);
    check("mr_locked_out", locked_out, 0);
    check("mr_fail_cnt",   fail_cnt, 0);
    enter_code(good, 1'b1, 1'b0, "mr_after");
    idle();
    check("mr_after_unlocked", unlocked, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
